spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Sequences and shares the single SoC SPI bus between two requesters.
- Instruction-fetch port: reads from SPI flash.
- Data port: reads and writes SPI RAM.
- Owns flash_cs_n/ram_cs_n and start/done handshakes a shared SPI shift engine (engine drives spi_sclk/spi_mosi, samples spi_miso).
- Sits between the memory controller's address decode and the SPI engine.

Parameters:
- ADDR_W, 24, SPI device address width forwarded to the engine.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits (1..15).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous assert, active-high
- i_req  in  1  instruction read request; level, held until i_ack
- i_addr  in  ADDR_W  flash byte address
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  32  fetched word; valid from i_ack, held until next i_ack
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- d_addr  in  ADDR_W  RAM byte address
- d_wdata  in  32  write data, right-justified
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  read data, right-justified; held until next d_ack
- eng_start  out  1  one-cycle transaction start to SPI engine
- eng_sel  out  1  0 = flash, 1 = RAM
- eng_we  out  1  write transaction
- eng_nbytes  out  3  payload bytes (1, 2 or 4)
- eng_addr  out  ADDR_W  latched address
- eng_wdata  out  32  latched write data
- eng_done  in  1  engine completion pulse
- eng_rdata  in  32  engine read data, valid with eng_done
- eng_abort  out  1  one-cycle abort pulse (timeout only)
- flash_cs_n  out  1  flash chip select, active-low
- ram_cs_n  out  1  RAM chip select, active-low
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle timeout-error pulse, coincident with the ack

Behaviour:
- Reset, asynchronous on rst=1:
  - state IDLE, streak counter 0.
  - flash_cs_n=1, ram_cs_n=1.
  - i_ack, d_ack, eng_start, eng_abort, err, busy all 0.
  - i_rdata, d_rdata, eng_addr, eng_wdata all 0; eng_nbytes, eng_sel, eng_we 0.
  - Reset mid-transaction: both CS released immediately, no ack issued, pending work discarded.
- FSM IDLE -> START -> WAIT -> ACK -> IDLE; all outputs registered.
- IDLE:
  - If either request is high, select a winner and latch addr/we/size/wdata into eng_* registers.
  - Instruction grant always produces eng_we=0, eng_nbytes=4.
  - Next state START.
- START, one cycle:
  - eng_start=1.
  - Selected CS low (flash_cs_n if eng_sel=0, ram_cs_n if eng_sel=1).
  - eng_done is ignored in this cycle.
- WAIT:
  - CS held low; eng_* fields stable.
  - On eng_done=1, capture eng_rdata into the winner's rdata register; next state ACK.
- ACK, one cycle:
  - Winner's ack=1; both CS high.
  - Next state IDLE.
  - Data writes update d_rdata with whatever eng_rdata shows with eng_done.
- Latency: request seen in IDLE at cycle 0 -> eng_start at cycle 1 -> eng_done at cycle k -> ack at cycle k+1.
- CS is high for at least 2 cycles between transactions (ACK + IDLE).
- Arbitration when both requests are high in IDLE:
  - Data wins, unless streak == MAX_DATA_STREAK, in which case instruction wins.
- Streak counter:
  - Increments, saturating, on a data grant while i_req=1.
  - Clears on an instruction grant, or on any grant while i_req=0.
- Request dropped before ack: the transaction still completes and the ack still pulses; the requester ignores it.
- Exactly one of flash_cs_n/ram_cs_n is ever low; never both.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without eng_done: one-cycle eng_abort=1, winner's rdata=32'hFFFFFFFF, then ACK with err=1 alongside the ack.
  - eng_done on the same cycle as the timeout wins, and no error is raised.
- Undefined: WAIT waits indefinitely; eng_abort and err are tied to 0.

Test Plan:
- Assert rst mid-WAIT with ram_cs_n low -> ram_cs_n=1 and busy=0 in the same cycle; no d_ack; first request after release is served normally.
- i_req, i_addr=0x000100; engine returns eng_done 10 cycles after eng_start with eng_rdata=0xDEADBEEF:
  - eng_sel=0, eng_nbytes=4, flash_cs_n low from START through WAIT.
  - i_ack pulses one cycle; i_rdata=0xDEADBEEF.
- d_req, d_we=1, d_size=1, d_addr=0x000040, d_wdata=0x0000BEEF -> eng_sel=1, eng_we=1, eng_nbytes=2, eng_wdata=0x0000BEEF, ram_cs_n low, one d_ack.
- i_req and d_req rise in the same cycle -> data granted first; instruction granted next; CS high for ≥2 cycles between the two transactions.
- MAX_DATA_STREAK=2, both requests held continuously and re-raised after each ack -> grant order D, D, I, D, D, I.
- SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never asserts eng_done -> eng_abort pulse after 16 WAIT cycles, then d_ack with err=1 and d_rdata=0xFFFFFFFF.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_arbiter
// Description : Shares one SPI shift engine between an instruction-fetch port
//               (SPI flash) and a data port (SPI RAM); owns both chip selects.
//               Optional WAIT watchdog enabled by macro SPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              eng_start,
    output logic              eng_sel,
    output logic              eng_we,
    output logic [2:0]        eng_nbytes,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [31:0]       eng_wdata,
    input  logic              eng_done,
    input  logic [31:0]       eng_rdata,
    output logic              eng_abort,
    output logic              flash_cs_n,
    output logic              ram_cs_n,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_abort = 3'd3;
    localparam logic [2:0] c_st_ack   = 3'd4;

    localparam logic [3:0] c_streak_max = 4'(MAX_DATA_STREAK);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_streak;
    logic       w_any_req;
    logic       w_grant_d;
    logic       w_grant;
    logic       w_sel_nxt;
    logic       w_cs_act_nxt;
    logic       w_timeout;
    logic       w_timeout_hit;
    logic [2:0] w_d_nbytes;

    always_comb begin
        w_any_req    = i_req | d_req;
        // Data normally wins; a full streak hands the bus to a waiting fetch.
        w_grant_d    = d_req & (~i_req | (r_streak != c_streak_max));
        w_grant      = (r_state == c_st_idle) & w_any_req;
        w_sel_nxt    = w_grant ? w_grant_d : eng_sel;
        w_timeout_hit = (r_state == c_st_wait) & ~eng_done & w_timeout;
        w_state_nxt  = r_state;
        case (r_state)
            c_st_idle:  if (w_any_req) w_state_nxt = c_st_start;
            c_st_start: w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (eng_done)       w_state_nxt = c_st_ack;
                else if (w_timeout) w_state_nxt = c_st_abort;
            end
            c_st_abort: w_state_nxt = c_st_ack;
            c_st_ack:   w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
        w_cs_act_nxt = (w_state_nxt == c_st_start) | (w_state_nxt == c_st_wait) |
                       (w_state_nxt == c_st_abort);
        case (d_size)
            2'd0:    w_d_nbytes = 3'd1;
            2'd1:    w_d_nbytes = 3'd2;
            default: w_d_nbytes = 3'd4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // All outputs are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak   <= 4'd0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            eng_start  <= 1'b0;
            eng_sel    <= 1'b0;
            eng_we     <= 1'b0;
            eng_nbytes <= 3'd0;
            eng_addr   <= '0;
            eng_wdata  <= 32'd0;
            flash_cs_n <= 1'b1;
            ram_cs_n   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            eng_start  <= (w_state_nxt == c_st_start);
            busy       <= (w_state_nxt != c_st_idle);
            flash_cs_n <= ~(w_cs_act_nxt & ~w_sel_nxt);
            ram_cs_n   <= ~(w_cs_act_nxt & w_sel_nxt);
            i_ack      <= (w_state_nxt == c_st_ack) & ~eng_sel;
            d_ack      <= (w_state_nxt == c_st_ack) & eng_sel;
            if (w_grant) begin
                eng_sel <= w_grant_d;
                if (w_grant_d) begin
                    eng_we     <= d_we;
                    eng_nbytes <= w_d_nbytes;
                    eng_addr   <= d_addr;
                    eng_wdata  <= d_wdata;
                end else begin
                    eng_we     <= 1'b0;
                    eng_nbytes <= 3'd4;
                    eng_addr   <= i_addr;
                    eng_wdata  <= 32'd0;
                end
                if (w_grant_d & i_req) begin
                    if (r_streak != c_streak_max) r_streak <= r_streak + 4'd1;
                end else begin
                    r_streak <= 4'd0;
                end
            end
            if ((r_state == c_st_wait) & eng_done) begin
                if (eng_sel) d_rdata <= eng_rdata;
                else         i_rdata <= eng_rdata;
            end else if (w_timeout_hit) begin
                if (eng_sel) d_rdata <= 32'hFFFF_FFFF;
                else         i_rdata <= 32'hFFFF_FFFF;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;

    assign w_timeout = (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 16'd0;
            eng_abort <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (r_state != c_st_wait) r_tmo_cnt <= 16'd0;
            else                      r_tmo_cnt <= r_tmo_cnt + 16'd1;
            eng_abort <= w_timeout_hit;
            // ABORT always leads into ACK, so the error lands with the ack.
            err       <= (r_state == c_st_abort);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign eng_abort = 1'b0;
    assign err       = 1'b0;
`endif

endmodule
`default_nettype wire
